// File: rtl/i2c_bus_recovery_if.sv
// Signal bundle between the filtered I2C lines, the open-drain pad enables
// and the bus supervisor / recovery sequencer.
interface i2c_bus_recovery_if;
    logic scl_in;
    logic sda_in;
    logic auto_en;
    logic recover_req;
    logic scl_oe;
    logic sda_oe;
    logic bus_busy;
    logic start_det;
    logic stop_det;
    logic stuck_det;
    logic recover_busy;
    logic recover_done;
    logic recover_fail;

    modport master (
        output scl_in, sda_in, auto_en, recover_req,
        input  scl_oe, sda_oe, bus_busy, start_det, stop_det, stuck_det,
               recover_busy, recover_done, recover_fail
    );

    modport slave (
        input  scl_in, sda_in, auto_en, recover_req,
        output scl_oe, sda_oe, bus_busy, start_det, stop_det, stuck_det,
               recover_busy, recover_done, recover_fail
    );
endinterface

// File: rtl/i2c_bus_recovery.sv
// I2C bus supervisor: START/STOP/busy monitor, SDA-stuck detector and the
// SCL-pulse + STOP recovery sequencer driving the open-drain pad enables.
module i2c_bus_recovery #(
    parameter int CLK_DIV       = 8,
    parameter int TIMEOUT_WIDTH = 16,
    parameter int TIMEOUT       = 1000,
    parameter int MAX_PULSES    = 9
) (
    input  logic              clk,
    input  logic              rst_l,
    i2c_bus_recovery_if.slave bus
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PCNT_W = $clog2(MAX_PULSES + 1);

    localparam logic [DIV_W-1:0]         DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]         DIV_ONE  = DIV_W'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] TO_MAX   = TIMEOUT_WIDTH'(TIMEOUT);
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST  = TIMEOUT_WIDTH'(TIMEOUT - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE   = TIMEOUT_WIDTH'(1);
    localparam logic [PCNT_W-1:0]        PCNT_MAX = PCNT_W'(MAX_PULSES);
    localparam logic [PCNT_W-1:0]        PCNT_ONE = PCNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_PULSE_LO    = 3'd1,
        S_PULSE_HI    = 3'd2,
        S_STOP_LO     = 3'd3,
        S_STOP_SCL_HI = 3'd4,
        S_STOP_SDA_HI = 3'd5,
        S_FAIL        = 3'd6
    } state_t;

    state_t                   state_r;
    logic                     scl_q_r;
    logic                     sda_q_r;
    logic                     start_det_r;
    logic                     stop_det_r;
    logic                     stuck_det_r;
    logic                     bus_busy_r;
    logic                     scl_oe_r;
    logic                     sda_oe_r;
    logic                     recover_busy_r;
    logic                     recover_done_r;
    logic                     recover_fail_r;
    logic [TIMEOUT_WIDTH-1:0] stuck_cnt_r;
    logic [TIMEOUT_WIDTH-1:0] stretch_cnt_r;
    logic [DIV_W-1:0]         div_cnt_r;
    logic [PCNT_W-1:0]        pulse_cnt_r;

    logic idle_s;
    logic start_s;
    logic stop_s;
    logic stuck_inc_s;
    logic trigger_s;
    logic div_last_s;
    logic stretch_last_s;
    logic last_pulse_s;

    // Bus conditions, counter terminal decodes and recovery trigger
    always_comb begin
        idle_s         = (state_r == S_IDLE);
        start_s        = idle_s & scl_q_r & bus.scl_in & sda_q_r & ~bus.sda_in;
        stop_s         = idle_s & scl_q_r & bus.scl_in & ~sda_q_r & bus.sda_in;
        stuck_inc_s    = idle_s & ~bus.sda_in & (bus.scl_in == scl_q_r);
        trigger_s      = bus.recover_req | (bus.auto_en & stuck_det_r);
        div_last_s     = (div_cnt_r == DIV_LAST);
        stretch_last_s = (stretch_cnt_r == TO_LAST);
        last_pulse_s   = ((pulse_cnt_r + PCNT_ONE) == PCNT_MAX);
    end

    // Line history, START/STOP pulses and the saturating SDA-stuck counter
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            scl_q_r     <= 1'b1;
            sda_q_r     <= 1'b1;
            start_det_r <= 1'b0;
            stop_det_r  <= 1'b0;
            stuck_det_r <= 1'b0;
            stuck_cnt_r <= '0;
        end else begin
            scl_q_r     <= bus.scl_in;
            sda_q_r     <= bus.sda_in;
            start_det_r <= start_s;
            stop_det_r  <= stop_s;
            stuck_det_r <= 1'b0;
            if (!stuck_inc_s) begin
                stuck_cnt_r <= '0;
            end else if (stuck_cnt_r != TO_MAX) begin
                stuck_cnt_r <= stuck_cnt_r + TO_ONE;
                stuck_det_r <= (stuck_cnt_r == TO_LAST);
            end
        end
    end

    // Recovery sequencer; the SCL high phases only count cycles where SCL is
    // actually seen high, so stretching or slow rise lengthens them.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_r        <= S_IDLE;
            div_cnt_r      <= '0;
            stretch_cnt_r  <= '0;
            pulse_cnt_r    <= '0;
            scl_oe_r       <= 1'b0;
            sda_oe_r       <= 1'b0;
            bus_busy_r     <= 1'b0;
            recover_busy_r <= 1'b0;
            recover_done_r <= 1'b0;
            recover_fail_r <= 1'b0;
        end else begin
            recover_done_r <= 1'b0;
            recover_fail_r <= 1'b0;
            if (start_s) begin
                bus_busy_r <= 1'b1;
            end else if (stop_s) begin
                bus_busy_r <= 1'b0;
            end
            case (state_r)
                S_IDLE: begin
                    if (trigger_s) begin
                        state_r        <= S_PULSE_LO;
                        div_cnt_r      <= '0;
                        pulse_cnt_r    <= '0;
                        scl_oe_r       <= 1'b1;
                        sda_oe_r       <= 1'b0;
                        recover_busy_r <= 1'b1;
                    end
                end
                S_PULSE_LO: begin
                    if (div_last_s) begin
                        state_r       <= S_PULSE_HI;
                        div_cnt_r     <= '0;
                        stretch_cnt_r <= '0;
                        scl_oe_r      <= 1'b0;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end
                S_PULSE_HI: begin
                    if (!bus.scl_in) begin
                        if (stretch_last_s) begin
                            state_r        <= S_FAIL;
                            div_cnt_r      <= '0;
                            recover_fail_r <= 1'b1;
                        end else begin
                            stretch_cnt_r <= stretch_cnt_r + TO_ONE;
                        end
                    end else if (div_last_s) begin
                        pulse_cnt_r <= pulse_cnt_r + PCNT_ONE;
                        div_cnt_r   <= '0;
                        if (bus.sda_in) begin
                            state_r  <= S_STOP_LO;
                            scl_oe_r <= 1'b1;
                            sda_oe_r <= 1'b1;
                        end else if (last_pulse_s) begin
                            state_r        <= S_FAIL;
                            recover_fail_r <= 1'b1;
                        end else begin
                            state_r  <= S_PULSE_LO;
                            scl_oe_r <= 1'b1;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end
                S_STOP_LO: begin
                    if (div_last_s) begin
                        state_r       <= S_STOP_SCL_HI;
                        div_cnt_r     <= '0;
                        stretch_cnt_r <= '0;
                        scl_oe_r      <= 1'b0;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end
                S_STOP_SCL_HI: begin
                    if (!bus.scl_in) begin
                        if (stretch_last_s) begin
                            state_r        <= S_FAIL;
                            div_cnt_r      <= '0;
                            sda_oe_r       <= 1'b0;
                            recover_fail_r <= 1'b1;
                        end else begin
                            stretch_cnt_r <= stretch_cnt_r + TO_ONE;
                        end
                    end else if (div_last_s) begin
                        state_r   <= S_STOP_SDA_HI;
                        div_cnt_r <= '0;
                        sda_oe_r  <= 1'b0;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end
                S_STOP_SDA_HI: begin
                    if (!div_last_s) begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end else if (bus.sda_in) begin
                        state_r        <= S_IDLE;
                        div_cnt_r      <= '0;
                        recover_busy_r <= 1'b0;
                        recover_done_r <= 1'b1;
                        bus_busy_r     <= 1'b0;
                    end else begin
                        state_r        <= S_FAIL;
                        div_cnt_r      <= '0;
                        recover_fail_r <= 1'b1;
                    end
                end
                S_FAIL: begin
                    state_r        <= S_IDLE;
                    div_cnt_r      <= '0;
                    scl_oe_r       <= 1'b0;
                    sda_oe_r       <= 1'b0;
                    recover_busy_r <= 1'b0;
                end
                default: begin
                    state_r        <= S_IDLE;
                    div_cnt_r      <= '0;
                    scl_oe_r       <= 1'b0;
                    sda_oe_r       <= 1'b0;
                    recover_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.scl_oe       = scl_oe_r;
    assign bus.sda_oe       = sda_oe_r;
    assign bus.bus_busy     = bus_busy_r;
    assign bus.start_det    = start_det_r;
    assign bus.stop_det     = stop_det_r;
    assign bus.stuck_det    = stuck_det_r;
    assign bus.recover_busy = recover_busy_r;
    assign bus.recover_done = recover_done_r;
    assign bus.recover_fail = recover_fail_r;

endmodule

// File: tb/tb_i2c_bus_recovery.sv
// Bench for i2c_bus_recovery: line-monitor vector table, randomised line activity
// against a run-length reference model, and recovery sequences against expected pad traces.
module tb_i2c_bus_recovery;
    localparam int CLK_DIV    = 4;
    localparam int TIMEOUT    = 50;
    localparam int MAX_PULSES = 9;

    logic clk         = 1'b0;
    logic rst_l       = 1'b0;
    logic ext_scl_low = 1'b0;
    logic sda_hold    = 1'b0;
    int   n_tests     = 0;
    int   n_fail      = 0;

    logic [4:0] rec[$];
    logic [1:0] expq[$];

    typedef struct {
        logic       scl;
        logic       sda;
        logic [2:0] exp;
    } vec_t;
    vec_t vt[12];

    i2c_bus_recovery_if bus ();

    // Open-drain wired-AND with zero-delay pull-ups
    assign bus.scl_in = ~(bus.scl_oe | ext_scl_low);
    assign bus.sda_in = ~(bus.sda_oe | sda_hold);

    i2c_bus_recovery #(
        .CLK_DIV(CLK_DIV), .TIMEOUT_WIDTH(16), .TIMEOUT(TIMEOUT), .MAX_PULSES(MAX_PULSES)
    ) dut (
        .clk(clk), .rst_l(rst_l), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] outs();
        return {bus.scl_oe, bus.sda_oe, bus.bus_busy, bus.start_det, bus.stop_det,
                bus.stuck_det, bus.recover_busy, bus.recover_done, bus.recover_fail};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic hold);
        rst_l           = 1'b0;
        bus.auto_en     = 1'b0;
        bus.recover_req = 1'b0;
        ext_scl_low     = 1'b0;
        sda_hold        = hold;
        tick();
        rst_l = 1'b1;
    endtask

    // Expected {scl_oe, sda_oe} per busy cycle; hi1 is the length of the first high phase
    task automatic build_exp(input int pulses, input int hi1, input bit with_stop);
        expq.delete();
        for (int p = 0; p < pulses; p++) begin
            repeat (CLK_DIV) expq.push_back(2'b10);
            repeat ((p == 0) ? hi1 : CLK_DIV) expq.push_back(2'b00);
        end
        if (with_stop) begin
            repeat (CLK_DIV) expq.push_back(2'b11);
            repeat (CLK_DIV) expq.push_back(2'b01);
            repeat (CLK_DIV) expq.push_back(2'b00);
        end
    endtask

    // Record {scl_oe, sda_oe, recover_busy, recover_done, recover_fail} from the cycle after the trigger edge
    task automatic capture(input int stretch, input int release_at, input int req2_at);
        int   rises;
        int   left;
        logic prev_oe;
        bit   fell;
        rises   = 0;
        left    = 0;
        prev_oe = 1'b0;
        fell    = 1'b0;
        rec.delete();
        for (int i = 0; i < 400; i++) begin
            tick();
            if (i == 0) bus.recover_req = 1'b0;
            rec.push_back({bus.scl_oe, bus.sda_oe, bus.recover_busy, bus.recover_done, bus.recover_fail});
            if (!bus.recover_busy) return;
            if (bus.scl_oe && !prev_oe) begin
                rises++;
                if (rises == release_at) sda_hold = 1'b0;
            end
            if (!bus.scl_oe && prev_oe && !fell && stretch > 0) begin
                fell        = 1'b1;
                ext_scl_low = 1'b1;
                left        = stretch;
            end else if (left > 0) begin
                left--;
                if (left == 0) ext_scl_low = 1'b0;
            end
            if (i == req2_at) bus.recover_req = 1'b1;
            else if (i == req2_at + 1) bus.recover_req = 1'b0;
            prev_oe = bus.scl_oe;
        end
        n_tests++;
        n_fail++;
        $display("FAIL capture: recover_busy still high after 400 cycles");
    endtask

    task automatic check_trace(input string name, input bit ok_end);
        int         nb;
        int         bad;
        logic [4:0] want;
        nb  = expq.size() + (ok_end ? 0 : 1);
        bad = 0;
        check({name, " length"}, rec.size(), nb + 1);
        for (int i = 0; i < rec.size() && i <= nb; i++) begin
            if (i < expq.size()) want = {expq[i], 3'b100};
            else if (i < nb)     want = 5'b00101;
            else                 want = {3'b000, ok_end, 1'b0};
            if (rec[i] !== want) bad++;
        end
        check({name, " trace"}, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.auto_en     = 1'b0;
        bus.recover_req = 1'b0;

        // {scl, sda} -> {start_det, stop_det, bus_busy}, starting from reset line history 1/1
        vt[0]  = '{1'b1, 1'b1, 3'b000};
        vt[1]  = '{1'b1, 1'b0, 3'b101};
        vt[2]  = '{1'b1, 1'b0, 3'b001};
        vt[3]  = '{1'b0, 1'b0, 3'b001};
        vt[4]  = '{1'b0, 1'b1, 3'b001};
        vt[5]  = '{1'b1, 1'b1, 3'b001};
        vt[6]  = '{1'b1, 1'b0, 3'b101};
        vt[7]  = '{1'b1, 1'b1, 3'b010};
        vt[8]  = '{1'b0, 1'b1, 3'b000};
        vt[9]  = '{1'b0, 1'b0, 3'b000};
        vt[10] = '{1'b1, 1'b0, 3'b000};
        vt[11] = '{1'b1, 1'b1, 3'b010};

        do_reset(1'b0);
        check("reset outputs", outs(), 9'd0);

        for (int i = 0; i < 12; i++) begin
            ext_scl_low = ~vt[i].scl;
            sda_hold    = ~vt[i].sda;
            tick();
            check($sformatf("monitor vec%0d", i), {bus.start_det, bus.stop_det, bus.bus_busy}, vt[i].exp);
        end

        begin : rnd
            logic p_scl, p_sda, m_busy, r_scl, r_sda, e_start, e_stop, e_stuck;
            int   run, len;
            do_reset(1'b0);
            p_scl  = 1'b1;
            p_sda  = 1'b1;
            m_busy = 1'b0;
            run    = 0;
            for (int seg = 0; seg < 120; seg++) begin
                r_scl = 1'($urandom_range(0, 1));
                r_sda = 1'($urandom_range(0, 1));
                len   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(40, 60)) : int'($urandom_range(1, 3));
                for (int k = 0; k < len; k++) begin
                    ext_scl_low = ~r_scl;
                    sda_hold    = ~r_sda;
                    tick();
                    e_start = p_scl & r_scl & p_sda & ~r_sda;
                    e_stop  = p_scl & r_scl & ~p_sda & r_sda;
                    if (e_start) m_busy = 1'b1;
                    else if (e_stop) m_busy = 1'b0;
                    e_stuck = 1'b0;
                    if (!r_sda && r_scl == p_scl) begin
                        if (run < TIMEOUT) begin
                            run++;
                            e_stuck = (run == TIMEOUT);
                        end
                    end else begin
                        run = 0;
                    end
                    p_scl = r_scl;
                    p_sda = r_sda;
                    check("random monitor", outs(), {2'b00, m_busy, e_start, e_stop, e_stuck, 3'b000});
                end
            end
        end

        // Auto recovery: SDA stuck from reset release, slave lets go during the 3rd pulse
        begin : auto3
            int cyc;
            do_reset(1'b1);
            bus.auto_en = 1'b1;
            cyc = 0;
            while (!bus.stuck_det && cyc < 200) begin
                tick();
                cyc++;
            end
            check("stuck_det cycle", cyc, TIMEOUT);
            check("bus_busy before recovery", bus.bus_busy, 1);
            capture(0, 3, -1);
            build_exp(3, CLK_DIV, 1'b1);
            check_trace("auto 3 pulses", 1'b1);
            check("bus_busy after done", bus.bus_busy, 0);
        end

        // SDA held low forever: MAX_PULSES pulses, no STOP, one-cycle fail
        do_reset(1'b1);
        tick();
        bus.recover_req = 1'b1;
        capture(0, 0, -1);
        build_exp(MAX_PULSES, CLK_DIV, 1'b0);
        check_trace("stuck max pulses", 1'b0);
        check("bus_busy kept after fail", bus.bus_busy, 1);

        // 20-cycle stretch in the first high phase plus a second request while busy
        begin : stretch20
            int busy_seen;
            do_reset(1'b0);
            bus.recover_req = 1'b1;
            capture(20, 0, 5);
            build_exp(1, CLK_DIV + 20, 1'b1);
            check_trace("stretch 20", 1'b1);
            busy_seen = 0;
            repeat (10) begin
                tick();
                if (bus.recover_busy || bus.scl_oe) busy_seen++;
            end
            check("second request ignored", busy_seen, 0);
        end

        // SCL never released: stretch timeout
        do_reset(1'b0);
        bus.recover_req = 1'b1;
        capture(1000, 0, -1);
        build_exp(1, TIMEOUT, 1'b0);
        check_trace("stretch timeout", 1'b0);

        // Reset during pulse 4
        do_reset(1'b1);
        tick();
        bus.recover_req = 1'b1;
        tick();
        bus.recover_req = 1'b0;
        repeat (26) tick();
        check("pulse 4 scl_oe", {bus.scl_oe, bus.recover_busy, bus.bus_busy}, 3'b111);
        rst_l = 1'b0;
        tick();
        check("reset mid-recovery", outs(), 9'd0);
        rst_l    = 1'b1;
        sda_hold = 1'b0;
        repeat (3) tick();
        check("idle after reset", {bus.scl_oe, bus.sda_oe, bus.recover_busy}, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
